// File: rtl/mod5_serial_tx_pkg.sv
// Shared types and mod-5 arithmetic for the serial check link (transmitter and checker).
package mod5_pkg;

    localparam int MOD5_CHK_BITS = 3;

    typedef enum logic [1:0] {IDLE, DATA, CHECK} tx_state_t;

    typedef logic [2:0] mod5_res_t;

    // 2r+b is at most 9, so a single conditional subtract keeps the result in 0..4.
    function automatic mod5_res_t mod5_next(input mod5_res_t res, input logic b);
        logic [3:0] t;
        t = {res, 1'b0} + {3'b000, b};
        if (t >= 4'd5) begin
            t = t - 4'd5;
        end
        return t[2:0];
    endfunction

    function automatic mod5_res_t mod5_check(input mod5_res_t res);
        return mod5_next(res, 1'b0);
    endfunction

endpackage

// File: rtl/mod5_serial_tx_if.sv
// Parallel word handshake plus serial frame outputs of the mod-5 transmitter.
interface mod5_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             bit_valid;
    logic             dout;
    logic             frame_first;
    logic             frame_last;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, bit_valid, dout, frame_first, frame_last, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, bit_valid, dout, frame_first, frame_last, busy
    );
endinterface

// File: rtl/mod5_serial_tx_residue_tracker.sv
// Running remainder mod 5 of an MSB-first bit stream; shared with the receive-side checker.
module mod5_residue_tracker
    import mod5_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      clr,
    input  logic      en,
    input  logic      b,
    output mod5_res_t res
);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            res <= '0;
        end else if (en) begin
            res <= mod5_next(res, b);
        end
    end

endmodule

// File: rtl/mod5_serial_tx.sv
// Serialises a WIDTH-bit word MSB-first and appends a 3-bit field making the frame divisible by 5.
module mod5_serial_tx
    import mod5_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHK_BITS = MOD5_CHK_BITS
) (
    input logic             clk,
    input logic             resetn,
    mod5_serial_tx_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + CHK_BITS);
    typedef logic [CNT_W-1:0] cnt_t;

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [WIDTH-1:0] shreg;
    cnt_t             cnt;
    mod5_res_t        chk;
    mod5_res_t        res;
    logic             msb;
    logic             hs;
    logic             data_end;
    logic             chk_end;
    logic             dout_dec;

    assign msb      = shreg[WIDTH-1];
    assign hs       = bus.in_valid && (state == IDLE);
    assign data_end = (state == DATA) && (cnt == '0);
    assign chk_end  = (state == CHECK) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs)       state_nxt = DATA;
            DATA:    if (data_end) state_nxt = CHECK;
            CHECK:   if (chk_end)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (hs) begin
            cnt <= cnt_t'(WIDTH - 1);
        end else if (data_end) begin
            cnt <= cnt_t'(CHK_BITS - 1);
        end else if (chk_end) begin
            cnt <= '0;
        end else if (state != IDLE) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The check value must include the payload bit leaving on this same cycle.
    always_ff @(posedge clk) begin
        if (hs) begin
            shreg <= bus.in_data;
        end else if (state == DATA) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
        if (data_end) begin
            chk <= mod5_check(mod5_next(res, msb));
        end
    end

    mod5_residue_tracker u_res (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state != DATA),
        .en     (state == DATA),
        .b      (msb),
        .res    (res)
    );

    always_comb begin
        dout_dec = 1'b0;
        case (state)
            DATA:    dout_dec = msb;
            CHECK:   dout_dec = chk[cnt[1:0]];
            default: dout_dec = 1'b0;
        endcase
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.bit_valid   = (state != IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.dout        = dout_dec;
    assign bus.frame_first = (state == DATA) && (cnt == cnt_t'(WIDTH - 1));
    assign bus.frame_last  = chk_end;

endmodule

// File: doc/mod5_serial_tx.md
Name: mod5_serial_tx

Overview:
- Transmit end of the team's mod-5 serial check link.
- Accepts a WIDTH-bit parallel word over a valid/ready handshake and serialises it MSB-first.
- Appends a 3-bit check field so the whole transmitted frame, read as one binary number, is divisible by 5.
- A downstream mod-5 serial checker, reset at frame start, asserts its zero-remainder flag after the last frame bit.

Parameters:
- WIDTH, 8, payload width in bits; legal range 2..32.
- CHK_BITS, 3, check-field width; fixed at 3 (residues 0..4); not for override.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  payload word offered.
- in_data  input  WIDTH  payload word; sampled only on handshake.
- in_ready  output  1  block can accept a word.
- bit_valid  output  1  dout carries a frame bit this cycle.
- dout  output  1  serial frame bit, MSB-first.
- frame_first  output  1  high with the first payload bit (MSB).
- frame_last  output  1  high with the last check bit.
- busy  output  1  frame in progress.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, residue=0, bit counter=0.
  - After that edge: in_ready=1; bit_valid=0, dout=0, frame_first=0, frame_last=0, busy=0.
  - Reset mid-frame aborts the frame immediately; no further bits are emitted.
- Handshake: a word transfers on an edge where in_valid=1 and in_ready=1. in_ready equals (state==IDLE), combinational from state. in_data is held in a shift register.
- States:
  - IDLE: in_ready=1. On handshake go to DATA, counter=WIDTH-1, residue=0.
  - DATA: bit_valid=1 and dout=shift_reg[MSB] every cycle.
    - Each edge: residue <= (2*residue + dout) mod 5; shift left; counter decrements.
    - When counter==0, go to CHECK; counter=2; check register loaded with c=(2*r_final) mod 5, where r_final includes the last payload bit.
  - CHECK: bit_valid=1; dout=c[counter], MSB-first (c[2], c[1], c[0]).
    - After c[0]: go to IDLE, residue=0.
- Check value: V = D*8 + c, and V mod 5 = 0 by construction. Mapping r->c: 0->0, 1->2, 2->4, 3->1, 4->3.
- Latency: first payload bit is on dout in the cycle after the handshake edge. Frame length is exactly WIDTH+3 consecutive bit_valid cycles with no bubbles.
- Inter-frame gap: minimum one IDLE cycle, because in_ready is low during CHECK.
- frame_first: high only in the first DATA cycle. frame_last: high only on the c[0] cycle.
- busy=1 in DATA and CHECK.
- All outputs are registered or decoded from state/registers only. No combinational path from in_* to dout or bit_valid.
- in_valid while busy: ignored, not latched; the word stays with the upstream.
- Residue arithmetic: 3-bit values. next = 2r+b lies in 0..9; reduce by subtracting 5 when the result is >=5. The residue never leaves 0..4.

Decomposition:
- Package mod5_pkg:
  - enum tx_state_t {IDLE, DATA, CHECK};
  - typedef logic [2:0] mod5_res_t;
  - function mod5_next(res, bit) returning (2*res+bit) mod 5;
  - function mod5_check(res) returning (2*res) mod 5;
  - localparam MOD5_CHK_BITS=3.
- The checker side shares this package.
- One sub-module: mod5_residue_tracker. It holds the 3-bit residue register with clear and enable and the mod5_next update, and is reusable by receiver-side logic.

Test Plan:
- Reset, then D=8'h01 -> dout sequence 0000_0001_010 (c=2, V=10); frame_first on cycle 1, frame_last on cycle 11; in_ready returns to 1 on cycle 12.
- D=8'h81 (r=4) -> check bits 011 (V=1035). D=8'h2A (r=2) -> check bits 100 (V=340).
- D=8'hFF and D=8'h00 -> check bits 000; 11 bit_valid cycles each with no gaps; a reference mod-5 checker reports zero remainder after frame_last.
- in_valid held high for 3 words back-to-back -> each frame is 11 bits; exactly one idle cycle between frames; in_ready=0 throughout each frame; no word dropped or duplicated.
- resetn=0 on the 5th payload bit -> outputs 0 on the next cycle; after release in_ready=1; the next word D=8'h03 gives a clean frame with check bits 001 (V=25).
- Random sweep of all 256 payloads, plus a WIDTH=16 instance -> every frame value is divisible by 5; frame length is always WIDTH+3.
